// File: rtl/da_fir_pkg.sv
// rtl/da_fir_pkg.sv - shared types and constants for the DA FIR sequencer
package da_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_W_DEF     = 16;
  localparam int CNT_W_DEF      = 5;
  localparam int TAPS           = 64;
  localparam int ROM_GROUPS     = 8;
  localparam int TAPS_PER_GROUP = TAPS / ROM_GROUPS;

endpackage

// File: rtl/da_bit_counter.sv
// rtl/da_bit_counter.sv - bit-position up-counter with clear, enable and terminal count
module da_bit_counter #(
  parameter int CNT_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/da_fir_sequencer.sv
// rtl/da_fir_sequencer.sv - control FSM for the bit-serial distributed-arithmetic FIR
module da_fir_sequencer
  import da_fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load,
  output logic             enable,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             acc_sub,
  output logic [CNT_W-1:0] bit_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             cnt_clear;
  logic             cnt_en;

  // Counter restarts on load and wraps to zero when the last bit has been consumed.
  assign cnt_clear = (state == LOAD) || ((state == SHIFT) && tc);
  assign cnt_en    = (state == SHIFT);
  assign bit_idx   = count;

  da_bit_counter #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count),
    .tc     (tc)
  );

  // Strobes are registered alongside the state so each equals a decode of the state it enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      load      <= 1'b0;
      enable    <= 1'b0;
      acc_clear <= 1'b0;
      acc_en    <= 1'b0;
      acc_sub   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= LOAD;
            in_ready  <= 1'b0;
            load      <= 1'b1;
            acc_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state     <= SHIFT;
          load      <= 1'b0;
          acc_clear <= 1'b0;
          enable    <= 1'b1;
          acc_en    <= 1'b1;
          acc_sub   <= 1'b0;
        end
        SHIFT: begin
          if (tc) begin
            state     <= DONE;
            enable    <= 1'b0;
            acc_en    <= 1'b0;
            acc_sub   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            // The sign bit of a two's complement sample carries negative weight.
            acc_sub <= (count == CNT_W'(DATA_W - 2));
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          load      <= 1'b0;
          enable    <= 1'b0;
          acc_clear <= 1'b0;
          acc_en    <= 1'b0;
          acc_sub   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_fir_sequencer.sv
// tb/tb_da_fir_sequencer.sv - scoreboard bench for the DA FIR sequencer
module tb_da_fir_sequencer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             load;
  logic             enable;
  logic             acc_clear;
  logic             acc_en;
  logic             acc_sub;
  logic [CNT_W-1:0] bit_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  da_fir_sequencer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load      (load),
    .enable    (enable),
    .acc_clear (acc_clear),
    .acc_en    (acc_en),
    .acc_sub   (acc_sub),
    .bit_idx   (bit_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_total = 0;
  int   out_total = 0;
  int   load_total = 0;
  int   sh_cnt = 0;
  int   seq_err = 0;
  int   ld_cnt = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(cyc + DATA_W + 2);
    exp_total++;
  endtask

  // Monitor: tracks per-sample shift behaviour and compares each output against the scoreboard.
  always @(negedge clk) begin
    checks++;
    assert (!(load && enable) && !(acc_clear && acc_en))
    else begin
      errors++;
      $display("FAIL mutex: load=%0b enable=%0b acc_clear=%0b acc_en=%0b expected no overlap", load, enable, acc_clear, acc_en);
    end
    if (reset) begin
      sh_cnt  = 0;
      seq_err = 0;
      ld_cnt  = 0;
      prev_ov = 1'b0;
    end else begin
      if (load) begin
        load_total++;
        ld_cnt++;
        sh_cnt  = 0;
        seq_err = 0;
      end
      if (enable) begin
        if (bit_idx != CNT_W'(sh_cnt)) seq_err++;
        if (acc_sub != (sh_cnt == DATA_W - 1)) seq_err++;
        if (!acc_en) seq_err++;
        sh_cnt++;
      end
      if (out_valid && !prev_ov) begin
        out_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("out_cycle", cyc, exp_q.pop_front());
        end
        check("shift_count", sh_cnt, DATA_W);
        check("bit_seq_errors", seq_err, 0);
        check("load_cycles", ld_cnt, 1);
        ld_cnt = 0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send_one();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    push_exp();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int l0;
    int ov_seen;
    int acc_c[5];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_strobes", int'({in_ready, busy, load, enable, acc_clear, acc_en, acc_sub, out_valid}), int'(8'b1000_0000));
    check("idle_bit_idx", int'(bit_idx), 0);

    // Single sample, including the LOAD-cycle strobes
    send_one();
    check("load_cycle", int'({load, acc_clear, in_ready, enable, busy}), int'(5'b11001));
    wait_drain();

    // Backpressure for 10 cycles
    out_ready = 1'b0;
    send_one();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("out_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", int'({out_valid, enable, acc_en, in_ready}), int'(4'b1000));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", int'({in_ready, out_valid}), int'(2'b10));
    wait_drain();

    // Back-to-back: 5 samples, in_valid and out_ready held high
    l0 = load_total;
    k  = 0;
    n  = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (k < 5 && n < 300) begin
      if (in_ready) begin
        acc_c[k] = cyc;
        push_exp();
        k++;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", k, 5);
    for (int i = 1; i < 5; i++) check("b2b_spacing", acc_c[i] - acc_c[i-1], DATA_W + 3);
    wait_drain();
    check("b2b_loads", load_total - l0, 5);

    // Reset in the middle of shifting
    send_one();
    n = 0;
    while (!(enable && bit_idx == CNT_W'(7)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("bit7_timeout", 0, 1);
    reset = 1'b1;
    exp_total -= exp_q.size();
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_state", int'({busy, enable, in_ready, out_valid}), int'(4'b0010));
    check("mid_reset_bit_idx", int'(bit_idx), 0);
    reset   = 1'b0;
    ov_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("no_out_after_reset", ov_seen, 0);
    send_one();
    wait_drain();

    // in_valid toggled while shifting must be ignored
    send_one();
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      check("shift_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    wait_drain();

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("outputs_total", out_total, exp_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
